// File: rtl/glitch_filter_pkg.sv
// glitch_filter_pkg: shared defaults and the stability counter width helper.
package glitch_filter_pkg;
    localparam int CHANNELS_D      = 4;
    localparam int SYNC_STAGES_D   = 2;
    localparam int STABLE_CYCLES_D = 4;
    localparam int GCNT_W_D        = 8;

    function automatic int cnt_width(input int stable);
        return (stable <= 2) ? 1 : $clog2(stable);
    endfunction
endpackage

// File: rtl/glitch_filter_chan.sv
// glitch_filter_chan: one deglitch channel with synchroniser, stability counter,
// registered edge/glitch pulses and a saturating glitch tally.
module glitch_filter_chan
    import glitch_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_D,
    parameter int STABLE_CYCLES = STABLE_CYCLES_D,
    parameter int GCNT_W        = GCNT_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              clr_cnt,
    output logic              dout,
    output logic              rise,
    output logic              fall,
    output logic              glitch,
    output logic [GCNT_W-1:0] gcnt
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES:0]   shifted;
    logic [CW-1:0]          cnt;
    logic                   s, diff, commit, rej;

    assign shifted = {sync, din};
    assign s       = sync[SYNC_STAGES-1];
    assign diff    = s != dout;
    assign commit  = diff && cnt == LAST;
    assign rej     = !diff && cnt != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            dout   <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
            gcnt   <= '0;
        end else begin
            sync   <= shifted[SYNC_STAGES-1:0];
            rise   <= commit && s;
            fall   <= commit && !s;
            glitch <= rej;
            if (commit) begin
                dout <= s;
                cnt  <= '0;
            end else if (diff) begin
                cnt <= cnt + 1'b1;
            end else if (rej) begin
                cnt <= '0;
            end
            // clear takes precedence over a coincident glitch increment
            gcnt <= clr_cnt ? '0 : (rej && !(&gcnt)) ? gcnt + 1'b1 : gcnt;
        end
    end
endmodule

// File: rtl/glitch_filter.sv
// glitch_filter: CHANNELS independent deglitch channels with packed glitch tallies.
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int CHANNELS      = CHANNELS_D,
    parameter int SYNC_STAGES   = SYNC_STAGES_D,
    parameter int STABLE_CYCLES = STABLE_CYCLES_D,
    parameter int GCNT_W        = GCNT_W_D
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        din,
    input  logic                       clr_cnt,
    output logic [CHANNELS-1:0]        dout,
    output logic [CHANNELS-1:0]        rise,
    output logic [CHANNELS-1:0]        fall,
    output logic [CHANNELS-1:0]        glitch,
    output logic [CHANNELS*GCNT_W-1:0] glitch_cnt
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        glitch_filter_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .GCNT_W       (GCNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .din    (din[i]),
            .clr_cnt(clr_cnt),
            .dout   (dout[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .glitch (glitch[i]),
            .gcnt   (glitch_cnt[i*GCNT_W +: GCNT_W])
        );
    end
endmodule

// File: tb/tb_glitch_filter.sv
// tb_glitch_filter: directed checks on default, narrow-counter and single-cycle instances.
module tb_glitch_filter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [3:0]  din_a = '0, din_b = '0, din_c = '0;
    logic [3:0]  dout_a, rise_a, fall_a, glitch_a;
    logic [3:0]  dout_b, rise_b, fall_b, glitch_b;
    logic [3:0]  dout_c, rise_c, fall_c, glitch_c;
    logic [31:0] gcnt_a;
    logic [7:0]  gcnt_b;
    logic [15:0] gcnt_c;
    logic [3:0]  hist_c [0:15];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    glitch_filter u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .clr_cnt(clr_cnt), .dout(dout_a),
        .rise(rise_a), .fall(fall_a), .glitch(glitch_a), .glitch_cnt(gcnt_a)
    );

    glitch_filter #(.GCNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .clr_cnt(clr_cnt), .dout(dout_b),
        .rise(rise_b), .fall(fall_b), .glitch(glitch_b), .glitch_cnt(gcnt_b)
    );

    glitch_filter #(.STABLE_CYCLES(1), .SYNC_STAGES(1), .GCNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .din(din_c), .clr_cnt(clr_cnt), .dout(dout_c),
        .rise(rise_c), .fall(fall_c), .glitch(glitch_c), .glitch_cnt(gcnt_c)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: release reset with all inputs high
        din_a = 4'b1111;
        tick(); tick();
        check("rst_dout", 32'(dout_a), 0);
        check("rst_gcnt", gcnt_a, 0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t1_dout_e%0d", e), 32'(dout_a), (e >= 6) ? 15 : 0);
            check($sformatf("t1_rise_e%0d", e), 32'(rise_a), (e == 6) ? 15 : 0);
        end
        din_a = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // 2: 3-cycle pulse on channel 0 is rejected
        din_a = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 3) din_a = '0;
            check($sformatf("t2_glitch_e%0d", e), 32'(glitch_a), (e == 6) ? 1 : 0);
            check($sformatf("t2_dout_e%0d", e), 32'(dout_a), 0);
        end
        check("t2_gcnt0", 32'(gcnt_a[7:0]), 1);
        // 3: 4 high then low on channel 1
        din_a = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 4) din_a = '0;
            check($sformatf("t3_rise_e%0d", e), 32'(rise_a), (e == 6) ? 2 : 0);
            check($sformatf("t3_fall_e%0d", e), 32'(fall_a), (e == 10) ? 2 : 0);
            check($sformatf("t3_dout_e%0d", e), 32'(dout_a), (e >= 6 && e < 10) ? 2 : 0);
            check($sformatf("t3_glitch_e%0d", e), 32'(glitch_a), 0);
        end
        // 5: reset mid-count on channel 3
        din_a = 4'b1000;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("t5_rst_dout", 32'(dout_a), 0);
        check("t5_rst_rise", 32'(rise_a), 0);
        check("t5_rst_glitch", 32'(glitch_a), 0);
        check("t5_rst_gcnt", gcnt_a, 0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t5_rise_e%0d", e), 32'(rise_a), (e == 6) ? 8 : 0);
            check($sformatf("t5_glitch_e%0d", e), 32'(glitch_a), 0);
        end
        check("t5_dout", 32'(dout_a), 8);
        // 4: saturating 2-bit counter on channel 2, clear beats glitch
        for (int n = 1; n <= 6; n++) begin
            din_b = 4'b0100;
            tick(); tick();
            din_b = '0;
            tick(); tick();
            clr_cnt = (n == 6);
            tick();
            check($sformatf("t4_glitch_n%0d", n), 32'(glitch_b), 4);
            check($sformatf("t4_gcnt_n%0d", n), 32'(gcnt_b[5:4]), (n == 6) ? 0 : (n > 3 ? 3 : n));
            check($sformatf("t4_dout_n%0d", n), 32'(dout_b), 0);
            clr_cnt = 1'b0;
            tick(); tick(); tick();
        end
        // 6: STABLE_CYCLES=1, SYNC_STAGES=1, toggling every cycle
        for (int e = 0; e < 12; e++) begin
            hist_c[e] = (e % 2 == 1) ? 4'b0101 : 4'b1010;
            din_c = hist_c[e];
            tick();
            if (e >= 1) begin
                check($sformatf("t6_dout_e%0d", e), 32'(dout_c), 32'(hist_c[e-1]));
                check($sformatf("t6_glitch_e%0d", e), 32'(glitch_c), 0);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
